// File: rtl/niu_sii_pkg.sv
// Shared encodings, beat counts, FSM state type and parity helper for the NIU->SII launcher.
package niu_sii_pkg;

    localparam logic [1:0] REQ_RD   = 2'b00;
    localparam logic [1:0] REQ_WR64 = 2'b01;
    localparam logic [1:0] REQ_WR16 = 2'b10;
    localparam logic [1:0] REQ_RSVD = 2'b11;

    localparam int WR64_BEATS = 4;
    localparam int WR16_BEATS = 1;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        WAIT_CRED,
        HDR,
        PAYLD
    } state_t;

    // One even-parity bit per 16-bit lane of a 128-bit word.
    function automatic logic [7:0] par16x8(input logic [127:0] d);
        logic [7:0] p;
        for (int i = 0; i < 8; i++) begin
            p[i] = ^d[16*i +: 16];
        end
        return p;
    endfunction

endpackage

// File: rtl/niu_sii_cred_cnt.sv
// Up/down credit counter that saturates at its reset value and flags increments beyond it.
module niu_sii_cred_cnt #(
    parameter int CRED_W = 5,
    parameter int INIT   = 16
) (
    input  logic              iol2clk,
    input  logic              rst_l,
    input  logic              inc,
    input  logic              dec,
    output logic [CRED_W-1:0] cnt,
    output logic              ovf
);

    localparam logic [CRED_W-1:0] MAX = CRED_W'(INIT);

    assign ovf = inc && !dec && (cnt == MAX);

    always_ff @(posedge iol2clk or negedge rst_l) begin
        if (!rst_l) begin
            cnt <= MAX;
        end else if (inc && !dec && (cnt != MAX)) begin
            cnt <= cnt + CRED_W'(1);
        end else if (dec && !inc && (cnt != '0)) begin
            cnt <= cnt - CRED_W'(1);
        end
    end

endmodule

// File: rtl/niu_sii_req_launch.sv
// NIU->SII inbound DMA request launcher: buffers write payload, tracks OQ/BQ credits, emits header + beats.
// Optional `NIU_SII_PAR_INJ_EN adds par_inj, which corrupts parity bit 0 on the next header cycle.
module niu_sii_req_launch
    import niu_sii_pkg::*;
#(
    parameter int OQ_CREDITS = 16,
    parameter int BQ_CREDITS = 16,
    parameter int CRED_W     = 5
) (
    input  logic         iol2clk,
    input  logic         rst_l,
`ifdef NIU_SII_PAR_INJ_EN
    input  logic         par_inj,
`endif
    input  logic         req_vld,
    output logic         req_rdy,
    input  logic [1:0]   req_type,
    input  logic         req_bypass,
    input  logic [127:0] req_hdr,
    input  logic         wd_vld,
    output logic         wd_rdy,
    input  logic [127:0] wd_data,
    input  logic [15:0]  wd_be,
    output logic         niu_sii_hdr_vld,
    output logic         niu_sii_reqbypass,
    output logic         niu_sii_datareq,
    output logic         niu_sii_datareq16,
    output logic [127:0] niu_sii_data,
    output logic [7:0]   niu_sii_parity,
    output logic [15:0]  niu_sii_be,
    input  logic         sii_niu_oqdq,
    input  logic         sii_niu_bqdq,
    output logic         cred_err
);

    state_t              state, state_nxt;
    logic [1:0]          lat_type;
    logic                lat_bypass;
    logic [127:0]        lat_hdr;
    logic [127:0]        pay_data [WR64_BEATS];
    logic [15:0]         pay_be   [WR64_BEATS];
    logic [1:0]          beat_idx, beat_nxt, last_idx;
    logic                accept, illegal, hdr_load, pay_load;
    logic                sel_cred_ok, b2b_ok;
    logic                oq_dec, bq_dec, oq_ovf, bq_ovf;
    logic [CRED_W-1:0]   oq_cnt, bq_cnt, new_q_cnt;
    logic [127:0]        data_nxt;
    logic [15:0]         be_nxt;
    logic [7:0]          par_flip;

    niu_sii_cred_cnt #(.CRED_W(CRED_W), .INIT(OQ_CREDITS)) u_oq_cred (
        .iol2clk (iol2clk),
        .rst_l   (rst_l),
        .inc     (sii_niu_oqdq),
        .dec     (oq_dec),
        .cnt     (oq_cnt),
        .ovf     (oq_ovf)
    );

    niu_sii_cred_cnt #(.CRED_W(CRED_W), .INIT(BQ_CREDITS)) u_bq_cred (
        .iol2clk (iol2clk),
        .rst_l   (rst_l),
        .inc     (sii_niu_bqdq),
        .dec     (bq_dec),
        .cnt     (bq_cnt),
        .ovf     (bq_ovf)
    );

    always_comb begin
        state_nxt   = state;
        beat_nxt    = beat_idx;
        req_rdy     = 1'b0;
        wd_rdy      = 1'b0;
        hdr_load    = 1'b0;
        pay_load    = 1'b0;
        last_idx    = (lat_type == REQ_WR64) ? 2'(WR64_BEATS - 1) : 2'(WR16_BEATS - 1);
        sel_cred_ok = lat_bypass ? (bq_cnt != '0) : (oq_cnt != '0);
        // A follow-on read must still have credit after the launch happening this cycle.
        new_q_cnt   = req_bypass ? bq_cnt : oq_cnt;
        b2b_ok      = (req_type == REQ_RD) &&
                      ((req_bypass == lat_bypass) ? (new_q_cnt > CRED_W'(1)) : (new_q_cnt != '0));

        case (state)
            IDLE: begin
                req_rdy = 1'b1;
                if (req_vld) begin
                    case (req_type)
                        REQ_RD:             state_nxt = WAIT_CRED;
                        REQ_WR64, REQ_WR16: state_nxt = COLLECT;
                        default:            state_nxt = IDLE;
                    endcase
                end
            end
            COLLECT: begin
                wd_rdy = 1'b1;
                if (wd_vld) begin
                    if (beat_idx == last_idx) begin
                        beat_nxt  = '0;
                        state_nxt = WAIT_CRED;
                    end else begin
                        beat_nxt = beat_idx + 2'd1;
                    end
                end
            end
            WAIT_CRED: begin
                if (sel_cred_ok) state_nxt = HDR;
            end
            HDR: begin
                hdr_load = 1'b1;
                if (lat_type == REQ_RD) begin
                    req_rdy   = b2b_ok;
                    state_nxt = (req_vld && b2b_ok) ? HDR : IDLE;
                end else begin
                    beat_nxt  = '0;
                    state_nxt = PAYLD;
                end
            end
            PAYLD: begin
                pay_load = 1'b1;
                if (beat_idx == last_idx) begin
                    beat_nxt  = '0;
                    state_nxt = IDLE;
                end else begin
                    beat_nxt = beat_idx + 2'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        accept  = req_vld && req_rdy && (req_type != REQ_RSVD);
        illegal = req_vld && req_rdy && (req_type == REQ_RSVD);
        oq_dec  = hdr_load && !lat_bypass;
        bq_dec  = hdr_load && lat_bypass;

        data_nxt = '0;
        be_nxt   = '0;
        if (hdr_load) begin
            data_nxt = lat_hdr;
        end else if (pay_load) begin
            data_nxt = pay_data[beat_idx];
            be_nxt   = pay_be[beat_idx];
        end
    end

`ifdef NIU_SII_PAR_INJ_EN
    logic inj_armed;

    always_ff @(posedge iol2clk or negedge rst_l) begin
        if (!rst_l) begin
            inj_armed <= 1'b0;
        end else if (hdr_load && inj_armed) begin
            inj_armed <= par_inj;
        end else if (par_inj) begin
            inj_armed <= 1'b1;
        end
    end

    assign par_flip = {7'b0, hdr_load && inj_armed};
`else
    assign par_flip = '0;
`endif

    always_ff @(posedge iol2clk or negedge rst_l) begin
        if (!rst_l) begin
            state      <= IDLE;
            beat_idx   <= '0;
            lat_type   <= REQ_RD;
            lat_bypass <= 1'b0;
            lat_hdr    <= '0;
            cred_err   <= 1'b0;
            for (int i = 0; i < WR64_BEATS; i++) begin
                pay_data[i] <= '0;
                pay_be[i]   <= '0;
            end
        end else begin
            state    <= state_nxt;
            beat_idx <= beat_nxt;
            if (accept) begin
                lat_type   <= req_type;
                lat_bypass <= req_bypass;
                lat_hdr    <= req_hdr;
            end
            if (wd_rdy && wd_vld) begin
                pay_data[beat_idx] <= wd_data;
                pay_be[beat_idx]   <= wd_be;
            end
            if (illegal || oq_ovf || bq_ovf) cred_err <= 1'b1;
        end
    end

    // Interface outputs are registered, so each header/beat appears the cycle after its FSM slot.
    always_ff @(posedge iol2clk or negedge rst_l) begin
        if (!rst_l) begin
            niu_sii_hdr_vld   <= 1'b0;
            niu_sii_reqbypass <= 1'b0;
            niu_sii_datareq   <= 1'b0;
            niu_sii_datareq16 <= 1'b0;
            niu_sii_data      <= '0;
            niu_sii_be        <= '0;
            niu_sii_parity    <= '0;
        end else begin
            niu_sii_hdr_vld   <= hdr_load;
            niu_sii_reqbypass <= hdr_load && lat_bypass;
            niu_sii_datareq   <= hdr_load && (lat_type != REQ_RD);
            niu_sii_datareq16 <= hdr_load && (lat_type == REQ_WR16);
            niu_sii_data      <= data_nxt;
            niu_sii_be        <= be_nxt;
            niu_sii_parity    <= par16x8(data_nxt) ^ par_flip;
        end
    end

endmodule

// File: tb/tb_niu_sii_req_launch.sv
// Directed self-checking bench for niu_sii_req_launch: reads, writes, credit stall/overflow, mid-packet reset.
module tb_niu_sii_req_launch;
    import niu_sii_pkg::*;

    logic         iol2clk = 1'b0;
    logic         rst_l   = 1'b0;
`ifdef NIU_SII_PAR_INJ_EN
    logic         par_inj = 1'b0;
`endif
    logic         req_vld, req_rdy, req_bypass;
    logic [1:0]   req_type;
    logic [127:0] req_hdr;
    logic         wd_vld, wd_rdy;
    logic [127:0] wd_data;
    logic [15:0]  wd_be;
    logic         niu_sii_hdr_vld, niu_sii_reqbypass, niu_sii_datareq, niu_sii_datareq16;
    logic [127:0] niu_sii_data;
    logic [7:0]   niu_sii_parity;
    logic [15:0]  niu_sii_be;
    logic         sii_niu_oqdq, sii_niu_bqdq, cred_err;

    int total = 0;
    int bad   = 0;

    logic [127:0] beat_d [4] = '{128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210,
                                 128'h1111_2222_3333_4444_5555_6666_7777_8888,
                                 128'hDEAD_BEEF_CAFE_F00D_0BAD_F00D_1357_9BDF,
                                 128'hFFFF_0000_A5A5_5A5A_0001_8000_7FFE_C3C3};
    logic [15:0]  beat_be [4] = '{16'hFFFF, 16'h00FF, 16'hF0F0, 16'h0001};

    always #5 iol2clk = ~iol2clk;

    niu_sii_req_launch dut (
        .iol2clk           (iol2clk),
        .rst_l             (rst_l),
`ifdef NIU_SII_PAR_INJ_EN
        .par_inj           (par_inj),
`endif
        .req_vld           (req_vld),
        .req_rdy           (req_rdy),
        .req_type          (req_type),
        .req_bypass        (req_bypass),
        .req_hdr           (req_hdr),
        .wd_vld            (wd_vld),
        .wd_rdy            (wd_rdy),
        .wd_data           (wd_data),
        .wd_be             (wd_be),
        .niu_sii_hdr_vld   (niu_sii_hdr_vld),
        .niu_sii_reqbypass (niu_sii_reqbypass),
        .niu_sii_datareq   (niu_sii_datareq),
        .niu_sii_datareq16 (niu_sii_datareq16),
        .niu_sii_data      (niu_sii_data),
        .niu_sii_parity    (niu_sii_parity),
        .niu_sii_be        (niu_sii_be),
        .sii_niu_oqdq      (sii_niu_oqdq),
        .sii_niu_bqdq      (sii_niu_bqdq),
        .cred_err          (cred_err)
    );

    task automatic tick();
        @(posedge iol2clk);
        #2;
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic vld, input logic [1:0] typ, input logic byp,
                                 input logic [127:0] hdr);
        req_vld    = vld;
        req_type   = typ;
        req_bypass = byp;
        req_hdr    = hdr;
    endtask

    function automatic logic [7:0] expParity(input logic [127:0] d);
        logic [7:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 16; j++) begin
                p[i] = p[i] ^ d[16*i + j];
            end
        end
        return p;
    endfunction

    task automatic sendBeats(input int n, input int off);
        for (int i = 0; i < n; i++) begin
            wd_vld  = 1'b1;
            wd_data = beat_d[(i + off) % 4];
            wd_be   = beat_be[(i + off) % 4];
            if (i == 0) begin
                #1;
                checkOutput("wd_rdy_collect", 128'(wd_rdy), 128'(1));
            end
            tick();
        end
        wd_vld = 1'b0;
    endtask

    task automatic waitHdr(input int max_cycles, output logic found);
        found = 1'b0;
        for (int c = 0; c < max_cycles && !found; c++) begin
            tick();
            if (niu_sii_hdr_vld) found = 1'b1;
        end
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_ctl"}, 128'({niu_sii_hdr_vld, niu_sii_reqbypass, niu_sii_datareq,
                                          niu_sii_datareq16, niu_sii_parity, niu_sii_be}), 128'(0));
        checkOutput({tag, "_data"}, niu_sii_data, 128'(0));
    endtask

    task automatic checkHeader(input string tag, input logic [127:0] hdr, input logic byp,
                               input logic dreq, input logic dreq16);
        checkOutput({tag, "_vld"}, 128'(niu_sii_hdr_vld), 128'(1));
        checkOutput({tag, "_flags"}, 128'({niu_sii_reqbypass, niu_sii_datareq, niu_sii_datareq16}),
                    128'({byp, dreq, dreq16}));
        checkOutput({tag, "_data"}, niu_sii_data, hdr);
        checkOutput({tag, "_par"}, 128'(niu_sii_parity), 128'(expParity(hdr)));
        checkOutput({tag, "_be"}, 128'(niu_sii_be), 128'(0));
    endtask

    task automatic checkBeat(input string tag, input int idx);
        checkOutput({tag, "_data"}, niu_sii_data, beat_d[idx]);
        checkOutput({tag, "_be"}, 128'(niu_sii_be), 128'(beat_be[idx]));
        checkOutput({tag, "_par"}, 128'(niu_sii_parity), 128'(expParity(beat_d[idx])));
        checkOutput({tag, "_ctl"}, 128'({niu_sii_hdr_vld, niu_sii_datareq}), 128'(0));
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [127:0] base;
        logic         found, acc, seen_any;
        int           sent, seen;

        applyStimulus(1'b0, REQ_RD, 1'b0, '0);
        wd_vld       = 1'b0;
        wd_data      = '0;
        wd_be        = '0;
        sii_niu_oqdq = 1'b0;
        sii_niu_bqdq = 1'b0;

        // Reset values
        tick();
        tick();
        checkIdleOutputs("rst");
        checkOutput("rst_cred_err", 128'(cred_err), 128'(0));
        checkOutput("rst_oq", 128'(dut.oq_cnt), 128'(16));
        checkOutput("rst_bq", 128'(dut.bq_cnt), 128'(16));
        rst_l = 1'b1;
        tick();
        checkOutput("idle_req_rdy", 128'(req_rdy), 128'(1));

        // Ordered read: header two cycles after acceptance
        applyStimulus(1'b1, REQ_RD, 1'b0, 128'hAAAA_0001_0000_0000_0000_0000_1234_5678);
        tick();
        applyStimulus(1'b0, REQ_RD, 1'b0, '0);
        tick();
        checkOutput("rd_not_early", 128'(niu_sii_hdr_vld), 128'(0));
        tick();
        checkHeader("rd_hdr", 128'hAAAA_0001_0000_0000_0000_0000_1234_5678, 1'b0, 1'b0, 1'b0);
        checkOutput("rd_oq", 128'(dut.oq_cnt), 128'(15));
        tick();
        checkIdleOutputs("rd_after");

        // Bypass write64 with four payload beats
        applyStimulus(1'b1, REQ_WR64, 1'b1, 128'hBBBB_0002_FFFF_0000_1111_2222_3333_4444);
        tick();
        applyStimulus(1'b0, REQ_RD, 1'b0, '0);
        sendBeats(4, 0);
        tick();
        tick();
        checkHeader("w64_hdr", 128'hBBBB_0002_FFFF_0000_1111_2222_3333_4444, 1'b1, 1'b1, 1'b0);
        checkOutput("w64_bq", 128'(dut.bq_cnt), 128'(15));
        checkOutput("w64_oq", 128'(dut.oq_cnt), 128'(15));
        for (int i = 0; i < 4; i++) begin
            tick();
            checkBeat($sformatf("w64_beat%0d", i), i);
        end
        tick();
        checkIdleOutputs("w64_end");

        // Ordered write16: exactly one beat, then back to IDLE
        applyStimulus(1'b1, REQ_WR16, 1'b0, 128'hCCCC_0003_0000_1111_0000_2222_0000_3333);
        tick();
        applyStimulus(1'b0, REQ_RD, 1'b0, '0);
        sendBeats(1, 2);
        tick();
        tick();
        checkHeader("w16_hdr", 128'hCCCC_0003_0000_1111_0000_2222_0000_3333, 1'b0, 1'b1, 1'b1);
        checkOutput("w16_oq", 128'(dut.oq_cnt), 128'(14));
        tick();
        checkBeat("w16_beat", 2);
        tick();
        checkIdleOutputs("w16_end");
        checkOutput("w16_idle_rdy", 128'(req_rdy), 128'(1));

        // Refill OQ to 16, then stream 17 reads: 16 launch back-to-back, the 17th stalls
        sii_niu_oqdq = 1'b1;
        tick();
        tick();
        sii_niu_oqdq = 1'b0;
        checkOutput("refill_oq", 128'(dut.oq_cnt), 128'(16));
        base = 128'hD000_0000_0000_0000_0000_0000_0000_0000;
        sent = 0;
        seen = 0;
        applyStimulus(1'b1, REQ_RD, 1'b0, base);
        for (int c = 0; c < 60; c++) begin
            #1;
            acc = req_vld && req_rdy;
            tick();
            if (niu_sii_hdr_vld) begin
                checkOutput($sformatf("b2b_hdr%0d", seen), niu_sii_data, base + 128'(seen));
                seen++;
            end
            if (acc) begin
                sent++;
                req_hdr = base + 128'(sent);
                if (sent == 17) req_vld = 1'b0;
            end
        end
        checkOutput("b2b_sent", 128'(sent), 128'(17));
        checkOutput("b2b_seen", 128'(seen), 128'(16));
        checkOutput("b2b_oq_empty", 128'(dut.oq_cnt), 128'(0));
        checkOutput("stall_req_rdy", 128'(req_rdy), 128'(0));
        sii_niu_oqdq = 1'b1;
        tick();
        sii_niu_oqdq = 1'b0;
        waitHdr(6, found);
        checkOutput("stall_released", 128'(found), 128'(1));
        checkOutput("stall_hdr_data", niu_sii_data, base + 128'(16));
        checkOutput("stall_oq", 128'(dut.oq_cnt), 128'(0));

        // Credit overflow saturates and sets the sticky error
        sii_niu_oqdq = 1'b1;
        repeat (16) tick();
        checkOutput("ovf_oq_full", 128'(dut.oq_cnt), 128'(16));
        checkOutput("ovf_no_err_yet", 128'(cred_err), 128'(0));
        tick();
        sii_niu_oqdq = 1'b0;
        checkOutput("ovf_err", 128'(cred_err), 128'(1));
        checkOutput("ovf_oq_sat", 128'(dut.oq_cnt), 128'(16));

        // Launch and dequeue in the same cycle leave the credit unchanged
        applyStimulus(1'b1, REQ_RD, 1'b0, 128'hEEEE_0004_0000_0000_5555_5555_0000_0001);
        tick();
        applyStimulus(1'b0, REQ_RD, 1'b0, '0);
        tick();
        sii_niu_oqdq = 1'b1;
        tick();
        sii_niu_oqdq = 1'b0;
        checkHeader("simul_hdr", 128'hEEEE_0004_0000_0000_5555_5555_0000_0001, 1'b0, 1'b0, 1'b0);
        checkOutput("simul_oq", 128'(dut.oq_cnt), 128'(16));

        // Reset during the second payload beat of an ordered write64
        applyStimulus(1'b1, REQ_WR64, 1'b0, 128'hF0F0_0005_0000_0000_0000_0000_0000_0005);
        tick();
        applyStimulus(1'b0, REQ_RD, 1'b0, '0);
        sendBeats(4, 1);
        tick();
        tick();
        checkOutput("rstmid_oq_used", 128'(dut.oq_cnt), 128'(15));
        tick();
        tick();
        checkOutput("rstmid_beat1", niu_sii_data, beat_d[2]);
        rst_l = 1'b0;
        #1;
        checkIdleOutputs("rstmid");
        checkOutput("rstmid_oq", 128'(dut.oq_cnt), 128'(16));
        checkOutput("rstmid_bq", 128'(dut.bq_cnt), 128'(16));
        checkOutput("rstmid_cred_err", 128'(cred_err), 128'(0));
        tick();
        rst_l = 1'b1;
        seen_any = 1'b0;
        repeat (6) begin
            tick();
            if (niu_sii_hdr_vld || (niu_sii_data != '0) || (niu_sii_be != '0)) seen_any = 1'b1;
        end
        checkOutput("rstmid_abandoned", 128'(seen_any), 128'(0));

        applyStimulus(1'b1, REQ_RD, 1'b1, 128'h1357_0006_2468_0000_0000_ABCD_0000_0006);
        tick();
        applyStimulus(1'b0, REQ_RD, 1'b0, '0);
        tick();
        tick();
        checkHeader("post_rst_hdr", 128'h1357_0006_2468_0000_0000_ABCD_0000_0006, 1'b1, 1'b0, 1'b0);
        checkOutput("post_rst_bq", 128'(dut.bq_cnt), 128'(15));

        // Reserved request type is dropped and flagged
        applyStimulus(1'b1, REQ_RSVD, 1'b0, 128'h7777_0007_0000_0000_0000_0000_0000_0007);
        #1;
        checkOutput("rsvd_rdy", 128'(req_rdy), 128'(1));
        tick();
        applyStimulus(1'b0, REQ_RD, 1'b0, '0);
        checkOutput("rsvd_err", 128'(cred_err), 128'(1));
        waitHdr(5, found);
        checkOutput("rsvd_dropped", 128'(found), 128'(0));
        checkOutput("rsvd_idle_rdy", 128'(req_rdy), 128'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
